// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, line levels
// and the default bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } txState_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int CLK_CNT_W            = 15;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with a registered full flag; read data is presented
// combinationally from the read pointer so a pop can consume it in the same cycle.
module byte_fifo #(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W   = FIFO_DEPTH_LOG2;
    localparam int COUNT_W = FIFO_DEPTH_LOG2 + 1;

    logic [7:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               full_q, full_d;
    logic               doPush, doPop;

    // A push is refused whenever the registered full flag is set, even if a
    // pop frees a slot in the same cycle.
    assign doPush  = push_i & ~full_q;
    assign doPop   = pop_i & (count_q != '0);
    assign data_o  = mem_q[rdPtr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == COUNT_W'(DEPTH));
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; queued bytes are sent as
// back-to-back frames with no idle gap on the line.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    txState_t             state_q, state_d;
    logic [CLK_CNT_W-1:0] clkCount_q, clkCount_d;
    logic [2:0]           bitIdx_q, bitIdx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 stopEnd_q, stopEnd_d;
    logic                 done_q;
    logic                 lastTick;

    logic                 fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [7:0]           fifoData;

    assign fifoPush = i_Tx_DV & ~fifoFull;

    byte_fifo #(
        .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clock_i (i_Clock),
        .reset_i (i_Reset),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .data_i  (i_Tx_Byte),
        .data_o  (fifoData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign lastTick = (clkCount_q == CLK_CNT_W'(CLKS_PER_BIT - 1));

    // Line outputs are registered from the current state, so the wire lags the
    // FSM by one clock; the done pulse takes a second stage to land after the
    // final stop-bit cycle has actually been driven.
    always_comb begin
        state_d    = state_q;
        clkCount_d = clkCount_q;
        bitIdx_d   = bitIdx_q;
        shift_d    = shift_q;
        fifoPop    = 1'b0;
        stopEnd_d  = 1'b0;
        serial_d   = STOP_BIT;
        active_d   = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                serial_d = STOP_BIT;
                if (!fifoEmpty) begin
                    fifoPop    = 1'b1;
                    shift_d    = fifoData;
                    bitIdx_d   = '0;
                    clkCount_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                serial_d = START_BIT;
                if (lastTick) begin
                    clkCount_d = '0;
                    state_d    = DATA;
                end else begin
                    clkCount_d = clkCount_q + CLK_CNT_W'(1);
                end
            end
            DATA: begin
                serial_d = shift_q[bitIdx_q];
                if (lastTick) begin
                    clkCount_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        bitIdx_d = '0;
                        state_d  = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    clkCount_d = clkCount_q + CLK_CNT_W'(1);
                end
            end
            STOP: begin
                serial_d = STOP_BIT;
                if (lastTick) begin
                    clkCount_d = '0;
                    stopEnd_d  = 1'b1;
                    if (!fifoEmpty) begin
                        fifoPop  = 1'b1;
                        shift_d  = fifoData;
                        bitIdx_d = '0;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clkCount_d = clkCount_q + CLK_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            clkCount_q <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            serial_q   <= STOP_BIT;
            active_q   <= 1'b0;
            stopEnd_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clkCount_q <= clkCount_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            stopEnd_q  <= stopEnd_d;
            done_q     <= stopEnd_q;
        end
    end

    assign o_Tx_Ready  = ~fifoFull;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

endmodule
